// File: rtl/scoreboard_chk.sv
// scoreboard_chk: in-order expected/actual scoreboard.
// An expected-value FIFO is filled by the stimulus side. Each act_valid is
// checked against the oldest entry. Mismatches and unexpected acts are counted
// into a saturating error counter; good compares go into a saturating match
// counter.
// Optional feature: define SCB_MASK_EN to add a per-entry compare mask input
// (exp_mask). A mask bit of 0 makes that data bit a don't-care.
module scoreboard_chk #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       exp_valid,
  input  logic [W-1:0]               exp_data,
`ifdef SCB_MASK_EN
  input  logic [W-1:0]               exp_mask,
`endif
  output logic                       exp_ready,
  input  logic                       act_valid,
  input  logic [W-1:0]               act_data,
  output logic                       mismatch,
  output logic                       unexpected,
  output logic [CW-1:0]              err_count,
  output logic [CW-1:0]              match_count,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       pass
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  data_mem [DEPTH];
`ifdef SCB_MASK_EN
  logic [W-1:0]  mask_mem [DEPTH];
`endif

  logic          push, pop, act_empty, diff, bad;
  logic [W-1:0]  head_diff;

  // Ready comes from registered occupancy only, so a same-cycle pop never
  // frees a slot for the push (no pass-through).
  assign exp_ready = (state != S_FULL);
  assign push      = exp_valid & exp_ready;
  assign pop       = act_valid & (state != S_EMPTY);
  assign act_empty = act_valid & (state == S_EMPTY);

`ifdef SCB_MASK_EN
  assign head_diff = (data_mem[rd_ptr] ^ act_data) & mask_mem[rd_ptr];
`else
  assign head_diff = data_mem[rd_ptr] ^ act_data;
`endif
  assign diff = |head_diff;
  assign bad  = (pop & diff) | act_empty;

  assign pass = (err_count == '0) && (pending == '0);

  // Storage array: no reset needed, pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      data_mem[wr_ptr] <= exp_data;
`ifdef SCB_MASK_EN
      mask_mem[wr_ptr] <= exp_mask;
`endif
    end
  end

  // Occupancy FSM, pointers, counters and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= '0;
      err_count   <= '0;
      match_count <= '0;
      mismatch    <= 1'b0;
      unexpected  <= 1'b0;
    end else if (clear) begin
      state       <= S_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pending     <= '0;
      err_count   <= '0;
      match_count <= '0;
      mismatch    <= 1'b0;
      unexpected  <= 1'b0;
    end else begin
      mismatch   <= pop & diff;
      unexpected <= act_empty;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      pending <= pending + PW'(1);
      else if (pop && !push) pending <= pending - PW'(1);
      if (bad && (err_count != '1))                 err_count   <= err_count + CW'(1);
      if (pop && !diff && (match_count != '1))      match_count <= match_count + CW'(1);
      case (state)
        S_EMPTY:  if (push) state <= S_ACTIVE;
        S_ACTIVE: begin
          if (push && !pop && (pending == PW'(DEPTH - 1))) state <= S_FULL;
          else if (pop && !push && (pending == PW'(1)))   state <= S_EMPTY;
        end
        S_FULL:   if (pop) state <= S_ACTIVE;
        default:  state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_chk.sv
// tb_scoreboard_chk: directed bench for scoreboard_chk with a queue-based
// reference model checked against the DUT every cycle, plus literal checks.
// Counter width is reduced so saturation is reachable in a short run.
module tb_scoreboard_chk;
  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clear, exp_valid, act_valid;
  logic [W-1:0]           exp_data, act_data, exp_mask;
  logic                   exp_ready, mismatch, unexpected, pass;
  logic [CW-1:0]          err_count, match_count;
  logic [$clog2(DEPTH):0] pending;

  scoreboard_chk #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data),
`ifdef SCB_MASK_EN
    .exp_mask(exp_mask),
`endif
    .exp_ready(exp_ready),
    .act_valid(act_valid), .act_data(act_data),
    .mismatch(mismatch), .unexpected(unexpected),
    .err_count(err_count), .match_count(match_count),
    .pending(pending), .pass(pass)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  // Reference model: a queue of expected entries and integer counters.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_mq[$];
  int m_err = 0, m_match = 0;
  bit m_mis = 0, m_unx = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clear) begin
        m_q.delete(); m_mq.delete();
        m_err = 0; m_match = 0; m_mis = 0; m_unx = 0;
      end else begin
        automatic int  pre  = m_q.size();
        automatic bit  take = exp_valid && (pre < DEPTH);
        m_mis = 0; m_unx = 0;
        if (act_valid) begin
          if (pre == 0) begin
            m_unx = 1;
            if (m_err < SAT) m_err++;
          end else begin
            if (((m_q[0] ^ act_data) & m_mq[0]) != 0) begin
              m_mis = 1;
              if (m_err < SAT) m_err++;
            end else if (m_match < SAT) m_match++;
            void'(m_q.pop_front()); void'(m_mq.pop_front());
          end
        end
        if (take) begin
          m_q.push_back(exp_data);
`ifdef SCB_MASK_EN
          m_mq.push_back(exp_mask);
`else
          m_mq.push_back('1);
`endif
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (run_chk) begin
      check("exp_ready",   exp_ready,   m_q.size() < DEPTH);
      check("mismatch",    mismatch,    m_mis);
      check("unexpected",  unexpected,  m_unx);
      check("err_count",   err_count,   m_err);
      check("match_count", match_count, m_match);
      check("pending",     pending,     m_q.size());
      check("pass",        pass,        (m_err == 0) && (m_q.size() == 0));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic step(input bit ev, input logic [W-1:0] ed, input logic [W-1:0] em,
                      input bit av, input logic [W-1:0] ad, input bit clr);
    exp_valid = ev; exp_data = ed; exp_mask = em;
    act_valid = av; act_data = ad; clear = clr;
    @(posedge clk); #2;
    exp_valid = 0; act_valid = 0; clear = 0;
  endtask

  task automatic idle(); step(0, 0, 8'hFF, 0, 0, 0); endtask
  task automatic do_clear(); step(0, 0, 8'hFF, 0, 0, 1); endtask

  logic [W-1:0] vals [3];

  initial begin
    rst_n = 0; clear = 0; exp_valid = 0; act_valid = 0;
    exp_data = 0; act_data = 0; exp_mask = 8'hFF;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    run_chk = 1;
    check("rst_ready",   exp_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_pass",    pass, 1);
    check("rst_err",     err_count, 0);

    // In-order matches
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1, vals[i], 8'hFF, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'hFF, 1, vals[i], 0);
    idle();
    check("t1_match", match_count, 3);
    check("t1_err",   err_count, 0);
    check("t1_pend",  pending, 0);
    check("t1_pass",  pass, 1);

    // Mismatch pulse
    do_clear();
    step(1, 8'hA5, 8'hFF, 0, 0, 0);
    step(0, 0, 8'hFF, 1, 8'h5A, 0);
    check("t2_mis",  mismatch, 1);
    check("t2_err",  err_count, 1);
    check("t2_pass", pass, 0);
    idle();
    check("t2_mis_end", mismatch, 0);

    // Unexpected on empty FIFO, including act in the same cycle as the first push
    do_clear();
    step(0, 0, 8'hFF, 1, 8'h44, 0);
    check("t3_unx",  unexpected, 1);
    check("t3_err",  err_count, 1);
    check("t3_pend", pending, 0);
    step(1, 8'h77, 8'hFF, 1, 8'h77, 0);
    check("t3_nobypass", unexpected, 1);
    check("t3_pend2",    pending, 1);
    idle();

    // Fill, refuse push at full, then wrap pointers
    do_clear();
    for (int i = 0; i < DEPTH; i++) step(1, W'(i), 8'hFF, 0, 0, 0);
    check("t4_full_rdy",  exp_ready, 0);
    check("t4_full_pend", pending, 16);
    step(1, 8'hEE, 8'hFF, 1, 8'h00, 0);
    check("t4_refuse_pend", pending, 15);
    check("t4_refuse_rdy",  exp_ready, 1);
    for (int k = 0; k < 20; k++)
      step(1, W'(100 + k), 8'hFF, 1, (k < 15) ? W'(k + 1) : W'(100 + k - 15), 0);
    check("t4_wrap_err",   err_count, 0);
    check("t4_wrap_match", match_count, SAT);
    check("t4_wrap_pend",  pending, 15);

    // Error counter saturation
    do_clear();
    for (int i = 0; i < SAT + 3; i++) step(0, 0, 8'hFF, 1, 8'h01, 0);
    check("t5_err_sat", err_count, SAT);

    // Clear beats simultaneous push/pop
    do_clear();
    for (int i = 0; i < 3; i++) step(1, W'(8'h50 + i), 8'hFF, 0, 0, 0);
    step(1, 8'h99, 8'hFF, 1, 8'h00, 1);
    check("t6_clr_pend", pending, 0);
    check("t6_clr_err",  err_count, 0);
    check("t6_clr_mis",  mismatch, 0);
    check("t6_clr_pass", pass, 1);
    idle();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1, W'(8'h60 + i), 8'hFF, 0, 0, 0);
    step(0, 0, 8'hFF, 1, 8'hFF, 0);
    exp_valid = 1; act_valid = 1; exp_data = 8'h12; act_data = 8'h34;
    rst_n = 0;
    @(posedge clk); #2;
    exp_valid = 0; act_valid = 0;
    rst_n = 1;
    check("t7_rst_pend",  pending, 0);
    check("t7_rst_err",   err_count, 0);
    check("t7_rst_match", match_count, 0);
    check("t7_rst_unx",   unexpected, 0);
    check("t7_rst_rdy",   exp_ready, 1);
    step(0, 0, 8'hFF, 1, 8'h60, 0);
    check("t7_stale", unexpected, 1);

`ifdef SCB_MASK_EN
    do_clear();
    step(1, 8'hF0, 8'hF0, 0, 0, 0);
    step(0, 0, 8'hFF, 1, 8'hF7, 0);
    check("t8_mask_match", match_count, 1);
    check("t8_mask_mis",   mismatch, 0);
    step(1, 8'hF0, 8'hF0, 0, 0, 0);
    step(0, 0, 8'hFF, 1, 8'h70, 0);
    check("t8_mask_hit", mismatch, 1);
`endif

    idle(); idle();
    run_chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
